// File: rtl/seg7_result_display.sv
// Registered 4-digit 7-segment output stage: captures a signed result, converts it with double-dabble,
// and scans the digits. Define SEG7_LEAD_ZERO_BLANK_EN to blank leading zero digits.
module seg7_result_display #(
  parameter int DATA_W      = 16,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              CLK_in,
  input  logic              RST_in,
  input  logic              load,
  input  logic [DATA_W-1:0] value,
  input  logic              err_in,
  output logic              busy,
  output logic              ovf,
  output logic [3:0]        led_active,
  output logic [7:0]        led_code
);
  localparam int CNT_W = $clog2(REFRESH_DIV + 1);
  localparam int STP_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0]  r_refresh_cnt;
  logic [1:0]        r_scan_idx;
  logic              r_busy;
  logic [STP_W-1:0]  r_step;
  logic [DATA_W-1:0] r_shift;
  logic [19:0]       r_bcd;
  logic              r_sign_p;
  logic              r_out_p;
  logic [15:0]       r_digits;
  logic              r_sign;
  logic              r_ovf;
  logic [3:0]        r_led_active;
  logic [7:0]        r_led_code;

  logic [DATA_W-1:0] w_mag;
  logic              w_out;
  logic [19:0]       w_bcd_adj;
  logic [3:0]        w_blank;
  logic [3:0]        w_nibble;
  logic [7:0]        w_code;
  int                w_value_int;

  assign w_value_int = int'($signed(value));
  assign w_mag       = value[DATA_W-1] ? (~value + DATA_W'(1)) : value;
  assign w_out       = (w_value_int < -999) || (w_value_int > 9999);

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_add3
      assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? (r_bcd[gi*4 +: 4] + 4'd3)
                                                                : r_bcd[gi*4 +: 4];
    end
  endgenerate

`ifdef SEG7_LEAD_ZERO_BLANK_EN
  // A digit is blank when it and everything to its left are zero; digit0 always shows.
  assign w_blank[0] = 1'b0;
  generate
    for (gi = 1; gi < 4; gi++) begin : g_blank
      assign w_blank[gi] = (r_digits[15:gi*4] == '0);
    end
  endgenerate
`else
  assign w_blank = 4'b0000;
`endif

  assign w_nibble = r_digits[r_scan_idx*4 +: 4];

  always_comb begin
    w_code = 8'hFF;
    if (err_in) begin
      case (r_scan_idx)
        2'd3:    w_code = 8'h86;
        2'd2:    w_code = 8'hAF;
        2'd1:    w_code = 8'hAF;
        default: w_code = 8'hFF;
      endcase
    end else if (r_ovf) begin
      w_code = 8'hBF;
    end else if (r_sign && (r_scan_idx == 2'd3)) begin
      w_code = 8'hBF;
    end else if (w_blank[r_scan_idx]) begin
      w_code = 8'hFF;
    end else begin
      case (w_nibble)
        4'd0:    w_code = 8'hC0;
        4'd1:    w_code = 8'hF9;
        4'd2:    w_code = 8'hA4;
        4'd3:    w_code = 8'hB0;
        4'd4:    w_code = 8'h99;
        4'd5:    w_code = 8'h92;
        4'd6:    w_code = 8'h82;
        4'd7:    w_code = 8'hF8;
        4'd8:    w_code = 8'h80;
        4'd9:    w_code = 8'h90;
        default: w_code = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge CLK_in) begin
    if (RST_in) begin
      r_refresh_cnt <= '0;
      r_scan_idx    <= 2'd0;
      r_led_active  <= 4'b1111;
      r_led_code    <= 8'hFF;
    end else begin
      if (r_refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        r_refresh_cnt <= '0;
        r_scan_idx    <= r_scan_idx + 2'd1;
      end else begin
        r_refresh_cnt <= r_refresh_cnt + CNT_W'(1);
      end
      r_led_active <= ~(4'b0001 << r_scan_idx);
      r_led_code   <= w_code;
    end
  end

  // A new load always restarts the converter, discarding any conversion in flight.
  always_ff @(posedge CLK_in) begin
    if (RST_in) begin
      r_busy   <= 1'b0;
      r_step   <= '0;
      r_shift  <= '0;
      r_bcd    <= '0;
      r_sign_p <= 1'b0;
      r_out_p  <= 1'b0;
      r_digits <= '0;
      r_sign   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (load) begin
      r_busy   <= 1'b1;
      r_step   <= '0;
      r_shift  <= w_mag;
      r_bcd    <= '0;
      r_sign_p <= value[DATA_W-1];
      r_out_p  <= w_out;
    end else if (r_busy) begin
      if (r_step == STP_W'(DATA_W)) begin
        r_busy   <= 1'b0;
        r_digits <= r_bcd[15:0];
        r_sign   <= r_sign_p;
        r_ovf    <= r_out_p || (r_bcd[19:16] != 4'd0);
      end else begin
        r_step  <= r_step + STP_W'(1);
        r_bcd   <= {w_bcd_adj[18:0], r_shift[DATA_W-1]};
        r_shift <= {r_shift[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign busy       = r_busy;
  assign ovf        = r_ovf;
  assign led_active = r_led_active;
  assign led_code   = r_led_code;
endmodule
